// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, control bundle.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_LDM   = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_STM   = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_JC    = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_ALU_0 = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_ALU_1 = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_ALU_2 = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_ALU_3 = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_MOV   = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_CMP   = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_FETCH2 = 4'd2,
    S_MEM_RD = 4'd3,
    S_LD_WB  = 4'd4,
    S_MEM_WR = 4'd5,
    S_JUMP   = 4'd6,
    S_ALU_EX = 4'd7,
    S_ALU_WB = 4'd8,
    S_MOV_WB = 4'd9,
    S_HALT   = 4'd10
  } ctrl_state_t;

  typedef struct packed {
    logic ld_pc;
    logic ld_ir;
    logic ld_tr;
    logic ld_alu;
    logic ld_czn;
    logic write_reg_en;
    logic sel_mem_src_pc;
    logic sel_mem_src_tr;
    logic mem_write;
    logic sel_pc_src_jump;
    logic sel_ir_3_2;
    logic sel_ir_4_3;
    logic sel_rf_write_src_tr_12_5;
    logic sel_rf_write_src_reg1;
    logic sel_rf_write_src_alu;
    logic sel_alu_src_reg1;
    logic sel_czn_src_alu;
    logic halted;
  } ctrl_sigs_t;

  // Two-byte instructions (LDM/STM/JMP/JC) share the 00xx prefix.
  function automatic logic op_is_two_byte(input logic [OPCODE_W-1:0] op);
    return op[3:2] == 2'b00;
  endfunction

  // ALU ops and CMP both go through the ALU execute state.
  function automatic logic op_uses_alu(input logic [OPCODE_W-1:0] op);
    return (op[3:2] == 2'b10) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode of the control state; only ld_PC in JUMP looks at an input.
// Build option: CTRL_WAIT_STATE_EN gates memory-state loads/strobes with mem_ready.
module control_decode
  import ctrl_pkg::*;
(
  input  ctrl_state_t               state,
  input  logic [OPCODE_W-1:0]       opcode,
  input  logic                      cond_true,
  input  logic                      mem_ready,
  output ctrl_sigs_t                sigs
);

  logic mem_ok;

`ifdef CTRL_WAIT_STATE_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // Per-state control bundle; everything not named in a state stays 0.
  always_comb begin
    sigs = '0;
    unique case (state)
      S_FETCH: begin
        sigs.sel_mem_src_pc = 1'b1;
        sigs.ld_ir          = mem_ok;
        sigs.ld_pc          = mem_ok;
      end
      S_DECODE: ;
      S_FETCH2: begin
        sigs.sel_mem_src_pc = 1'b1;
        sigs.ld_tr          = mem_ok;
        sigs.ld_pc          = mem_ok;
      end
      S_MEM_RD: begin
        sigs.sel_mem_src_tr = 1'b1;
        sigs.ld_tr          = mem_ok;
      end
      S_LD_WB: begin
        sigs.sel_ir_4_3               = 1'b1;
        sigs.sel_rf_write_src_tr_12_5 = 1'b1;
        sigs.write_reg_en             = 1'b1;
      end
      S_MEM_WR: begin
        sigs.sel_mem_src_tr = 1'b1;
        sigs.sel_ir_4_3     = 1'b1;
        sigs.mem_write      = mem_ok;
      end
      S_JUMP: begin
        sigs.sel_pc_src_jump = 1'b1;
        sigs.ld_pc           = (opcode == OP_JC) ? cond_true : 1'b1;
      end
      S_ALU_EX: begin
        sigs.sel_alu_src_reg1 = 1'b1;
        sigs.sel_ir_3_2       = 1'b1;
        sigs.ld_alu           = 1'b1;
        sigs.ld_czn           = 1'b1;
        sigs.sel_czn_src_alu  = 1'b1;
      end
      S_ALU_WB: begin
        sigs.sel_ir_3_2           = 1'b1;
        sigs.sel_rf_write_src_alu = 1'b1;
        sigs.write_reg_en         = 1'b1;
      end
      S_MOV_WB: begin
        sigs.sel_ir_3_2            = 1'b1;
        sigs.sel_rf_write_src_reg1 = 1'b1;
        sigs.write_reg_en          = 1'b1;
      end
      S_HALT: begin
        sigs.halted = 1'b1;
      end
      default: sigs = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: state register plus next-state logic; outputs come from control_decode.
// Build option: CTRL_WAIT_STATE_EN stalls FETCH/FETCH2/MEM_RD/MEM_WR until mem_ready.
module control_unit
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cond_true,
  input  logic                mem_ready,
  output logic                ld_PC,
  output logic                ld_IR,
  output logic                ld_TR,
  output logic                ld_ALU,
  output logic                ld_CZN,
  output logic                write_reg_en,
  output logic                sel_MEM_src_PC,
  output logic                sel_MEM_src_TR,
  output logic                mem_write,
  output logic                sel_PC_src_JUMP,
  output logic                sel_IR_3_2,
  output logic                sel_IR_4_3,
  output logic                sel_RF_write_src_TR_12_5,
  output logic                sel_RF_write_src_reg1,
  output logic                sel_RF_write_src_ALU,
  output logic                sel_ALU_src_reg1,
  output logic                sel_CZN_src_ALU,
  output logic                halted
);

  ctrl_state_t state, state_next;
  ctrl_sigs_t  sigs;
  logic        mem_ok;

`ifdef CTRL_WAIT_STATE_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic; opcode is held stable by IR outside FETCH.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:  state_next = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_is_two_byte(opcode))   state_next = S_FETCH2;
        else if (op_uses_alu(opcode)) state_next = S_ALU_EX;
        else if (opcode == OP_MOV)    state_next = S_MOV_WB;
        else if (opcode == OP_HALT)   state_next = S_HALT;
        else                          state_next = S_FETCH;
      end
      S_FETCH2: begin
        if (mem_ok) begin
          if (opcode == OP_LDM)      state_next = S_MEM_RD;
          else if (opcode == OP_STM) state_next = S_MEM_WR;
          else                       state_next = S_JUMP;
        end
      end
      S_MEM_RD: state_next = mem_ok ? S_LD_WB : S_MEM_RD;
      S_LD_WB:  state_next = S_FETCH;
      S_MEM_WR: state_next = mem_ok ? S_FETCH : S_MEM_WR;
      S_JUMP:   state_next = S_FETCH;
      S_ALU_EX: state_next = (opcode == OP_CMP) ? S_FETCH : S_ALU_WB;
      S_ALU_WB: state_next = S_FETCH;
      S_MOV_WB: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  control_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .cond_true (cond_true),
    .mem_ready (mem_ready),
    .sigs      (sigs)
  );

  // Flatten the control bundle onto the datapath-facing ports.
  assign ld_PC                    = sigs.ld_pc;
  assign ld_IR                    = sigs.ld_ir;
  assign ld_TR                    = sigs.ld_tr;
  assign ld_ALU                   = sigs.ld_alu;
  assign ld_CZN                   = sigs.ld_czn;
  assign write_reg_en             = sigs.write_reg_en;
  assign sel_MEM_src_PC           = sigs.sel_mem_src_pc;
  assign sel_MEM_src_TR           = sigs.sel_mem_src_tr;
  assign mem_write                = sigs.mem_write;
  assign sel_PC_src_JUMP          = sigs.sel_pc_src_jump;
  assign sel_IR_3_2               = sigs.sel_ir_3_2;
  assign sel_IR_4_3               = sigs.sel_ir_4_3;
  assign sel_RF_write_src_TR_12_5 = sigs.sel_rf_write_src_tr_12_5;
  assign sel_RF_write_src_reg1    = sigs.sel_rf_write_src_reg1;
  assign sel_RF_write_src_ALU     = sigs.sel_rf_write_src_alu;
  assign sel_ALU_src_reg1         = sigs.sel_alu_src_reg1;
  assign sel_CZN_src_ALU          = sigs.sel_czn_src_alu;
  assign halted                   = sigs.halted;

  // One-hot select groups must never have two bits set.
  a_mem_src_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sel_MEM_src_PC, sel_MEM_src_TR}));
  a_rf_dst_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sel_IR_3_2, sel_IR_4_3}));
  a_rf_src_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU}));

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle control vectors are queued
// per instruction and compared against the outputs each cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       cond_true;
  logic       mem_ready;
  logic ld_PC, ld_IR, ld_TR, ld_ALU, ld_CZN, write_reg_en;
  logic sel_MEM_src_PC, sel_MEM_src_TR, mem_write, sel_PC_src_JUMP;
  logic sel_IR_3_2, sel_IR_4_3;
  logic sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU;
  logic sel_ALU_src_reg1, sel_CZN_src_ALU, halted;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond_true(cond_true), .mem_ready(mem_ready),
    .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_TR(ld_TR), .ld_ALU(ld_ALU), .ld_CZN(ld_CZN),
    .write_reg_en(write_reg_en), .sel_MEM_src_PC(sel_MEM_src_PC),
    .sel_MEM_src_TR(sel_MEM_src_TR), .mem_write(mem_write),
    .sel_PC_src_JUMP(sel_PC_src_JUMP), .sel_IR_3_2(sel_IR_3_2), .sel_IR_4_3(sel_IR_4_3),
    .sel_RF_write_src_TR_12_5(sel_RF_write_src_TR_12_5),
    .sel_RF_write_src_reg1(sel_RF_write_src_reg1),
    .sel_RF_write_src_ALU(sel_RF_write_src_ALU), .sel_ALU_src_reg1(sel_ALU_src_reg1),
    .sel_CZN_src_ALU(sel_CZN_src_ALU), .halted(halted)
  );

  // Bit positions of each output in the observed vector.
  localparam logic [17:0] LPC  = 18'h1 << 17;
  localparam logic [17:0] LIR  = 18'h1 << 16;
  localparam logic [17:0] LTR  = 18'h1 << 15;
  localparam logic [17:0] LALU = 18'h1 << 14;
  localparam logic [17:0] LCZN = 18'h1 << 13;
  localparam logic [17:0] WRE  = 18'h1 << 12;
  localparam logic [17:0] MPC  = 18'h1 << 11;
  localparam logic [17:0] MTR  = 18'h1 << 10;
  localparam logic [17:0] MWR  = 18'h1 << 9;
  localparam logic [17:0] PJ   = 18'h1 << 8;
  localparam logic [17:0] I32  = 18'h1 << 7;
  localparam logic [17:0] I43  = 18'h1 << 6;
  localparam logic [17:0] RTR  = 18'h1 << 5;
  localparam logic [17:0] RR1  = 18'h1 << 4;
  localparam logic [17:0] RALU = 18'h1 << 3;
  localparam logic [17:0] AR1  = 18'h1 << 2;
  localparam logic [17:0] CZA  = 18'h1 << 1;
  localparam logic [17:0] HLT  = 18'h1 << 0;

  localparam logic [17:0] V_FETCH  = MPC | LIR | LPC;
  localparam logic [17:0] V_DECODE = 18'h0;
  localparam logic [17:0] V_FETCH2 = MPC | LTR | LPC;
  localparam logic [17:0] V_MEM_RD = MTR | LTR;
  localparam logic [17:0] V_LD_WB  = I43 | RTR | WRE;
  localparam logic [17:0] V_MEM_WR = MTR | I43 | MWR;
  localparam logic [17:0] V_ALU_EX = AR1 | I32 | LALU | LCZN | CZA;
  localparam logic [17:0] V_ALU_WB = I32 | RALU | WRE;
  localparam logic [17:0] V_MOV_WB = I32 | RR1 | WRE;
  localparam logic [17:0] V_HALT   = HLT;

  logic [17:0] sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [17:0] observe();
    return {ld_PC, ld_IR, ld_TR, ld_ALU, ld_CZN, write_reg_en, sel_MEM_src_PC,
            sel_MEM_src_TR, mem_write, sel_PC_src_JUMP, sel_IR_3_2, sel_IR_4_3,
            sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU,
            sel_ALU_src_reg1, sel_CZN_src_ALU, halted};
  endfunction

  // Single named comparison that steps the counters.
  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Compare the current cycle against the scoreboard head, then advance one clock.
  task automatic step(input string tag);
    logic [17:0] exp;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s_sb_empty observed=%0d expected=nonzero", tag, sb.size());
    end else begin
      exp = sb.pop_front();
      check(tag, observe(), exp);
    end
    @(posedge clk); #1;
  endtask

  // Reference sequence of per-cycle outputs for one instruction.
  task automatic push_seq(input logic [3:0] op, input logic cond);
    sb.push_back(V_FETCH);
    sb.push_back(V_DECODE);
    casez (op)
      4'b0000: begin sb.push_back(V_FETCH2); sb.push_back(V_MEM_RD); sb.push_back(V_LD_WB); end
      4'b0001: begin sb.push_back(V_FETCH2); sb.push_back(V_MEM_WR); end
      4'b0010: begin sb.push_back(V_FETCH2); sb.push_back(PJ | LPC); end
      4'b0011: begin sb.push_back(V_FETCH2); sb.push_back(cond ? (PJ | LPC) : PJ); end
      4'b10??: begin sb.push_back(V_ALU_EX); sb.push_back(V_ALU_WB); end
      4'b1100: sb.push_back(V_MOV_WB);
      4'b1101: sb.push_back(V_ALU_EX);
      4'b1111: sb.push_back(V_HALT);
      default: ;
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input logic cond);
    int n;
    opcode    = op;
    cond_true = cond;
    push_seq(op, cond);
    n = sb.size();
    repeat (n) step(tag);
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 4'b1110;
    cond_true = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: FETCH decode, not halted.
    check("reset_fetch", observe(), V_FETCH);
    check("reset_halted", {17'h0, halted}, 18'h0);

    run_instr("alu_add", 4'b1000, 1'b0);
    run_instr("alu_op3", 4'b1011, 1'b1);
    run_instr("ldm",     4'b0000, 1'b0);
    run_instr("jc_nt",   4'b0011, 1'b0);
    run_instr("jc_t",    4'b0011, 1'b1);
    run_instr("jmp",     4'b0010, 1'b0);
    run_instr("stm",     4'b0001, 1'b0);
    run_instr("mov",     4'b1100, 1'b0);
    run_instr("cmp",     4'b1101, 1'b1);
    run_instr("nop",     4'b1110, 1'b0);
    run_instr("undef",   4'b0101, 1'b1);

    // HALT then stays halted with all loads 0, regardless of inputs.
    run_instr("halt", 4'b1111, 1'b0);
    for (int i = 0; i < 21; i++) begin
      opcode    = 4'($urandom_range(0, 15));
      cond_true = 1'($urandom_range(0, 1));
      sb.push_back(V_HALT);
      step("halt_hold");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("halt_reset_fetch", observe(), V_FETCH);
    check("halt_reset_halted", {17'h0, halted}, 18'h0);

    // Reset while in MEM_WR of an STM: no strobe after the reset edge.
    opcode = 4'b0001;
    sb.push_back(V_FETCH);
    sb.push_back(V_DECODE);
    sb.push_back(V_FETCH2);
    repeat (3) step("stm_rst_pre");
    check("stm_rst_memwr", observe(), V_MEM_WR);
    rst = 1'b1;
    @(posedge clk); #1;
    check("stm_rst_after", observe(), V_FETCH);
    rst = 1'b0;
    run_instr("post_rst_ldm", 4'b0000, 1'b0);

`ifdef CTRL_WAIT_STATE_EN
    // Three wait cycles in FETCH: address select held, loads suppressed.
    opcode    = 4'b1110;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(MPC);
      step("wait_fetch");
    end
    mem_ready = 1'b1;
    sb.push_back(V_FETCH);
    sb.push_back(V_DECODE);
    step("wait_ready");
    step("wait_decode");
    check("wait_nop_done", observe(), V_FETCH);

    // Wait in MEM_WR: strobe only on the ready cycle.
    opcode = 4'b0001;
    sb.push_back(V_FETCH);
    sb.push_back(V_DECODE);
    sb.push_back(V_FETCH2);
    repeat (3) step("wait_stm_pre");
    mem_ready = 1'b0;
    sb.push_back(MTR | I43);
    sb.push_back(MTR | I43);
    repeat (2) step("wait_memwr");
    mem_ready = 1'b1;
    sb.push_back(V_MEM_WR);
    step("wait_memwr_rdy");
    check("wait_stm_done", observe(), V_FETCH);
`endif

    run_instr("final_nop", 4'b1110, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
